led_scan_arbiter: RTL

Shares the 8-digit multiplexed LED display datapath (digit-select one-hot plus 8-bit value to segment decoder) between up to N_REQ requesters. Grants the display round-robin, latches the winner's byte and sequences the digit scan. Holds the display for DWELL full scan frames, then releases it. Sits between the CPU/debug sources and the LED print/decoder block.

---
 rtl/led_scan_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/led_scan_arbiter.sv
// led_scan_arbiter: round-robin owner of the shared multiplexed LED display.
// It latches the winner's byte, scans the digits for DWELL frames, then releases.
module led_scan_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned N_DIG    = 8,
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned DWELL    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] data,
  input  logic               pause,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic [7:0]         disp_data,
  output logic [N_DIG-1:0]   digit_sel,
  output logic               frame_tick,
  output logic               busy
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FRM_W = $clog2(DWELL + 1);

  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(N_REQ - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(DWELL);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHOW    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t             r_state,     w_state_nxt;
  logic [PTR_W-1:0]   r_ptr,       w_ptr_nxt;
  logic [PTR_W-1:0]   r_owner,     w_owner_nxt;
  logic [IDX_W-1:0]   r_idx,       w_idx_nxt;
  logic [DIV_W-1:0]   r_div,       w_div_nxt;
  logic [FRM_W-1:0]   r_frm,       w_frm_nxt;
  logic [N_REQ-1:0]   r_grant,     w_grant_nxt;
  logic [N_REQ-1:0]   r_done,      w_done_nxt;
  logic [7:0]         r_disp,      w_disp_nxt;
  logic [N_DIG-1:0]   r_sel,       w_sel_nxt;
  logic               r_tick,      w_tick_nxt;
  logic               r_busy,      w_busy_nxt;

  logic [PTR_W-1:0]   w_winner;
  logic               w_found;
  logic [7:0]         w_win_data;
  logic               w_wrap;
  logic [FRM_W-1:0]   w_frm_inc;

  // Round-robin search: first requester above the pointer, wrapping.
  always_comb begin
    int unsigned cand;
    w_winner = '0;
    w_found  = 1'b0;
    cand     = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(r_ptr) + k) % N_REQ;
      if (!w_found && req[PTR_W'(cand)]) begin
        w_found  = 1'b1;
        w_winner = PTR_W'(cand);
      end
    end
  end

  // Byte of the requester that wins arbitration this cycle.
  always_comb begin
    w_win_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_winner == PTR_W'(i)) w_win_data = data[8*i +: 8];
    end
  end

  // Next-state and next-output logic; outputs are all registered.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_idx_nxt   = r_idx;
    w_div_nxt   = r_div;
    w_frm_nxt   = r_frm;
    w_grant_nxt = r_grant;
    w_done_nxt  = '0;
    w_disp_nxt  = r_disp;
    w_sel_nxt   = r_sel;
    w_tick_nxt  = 1'b0;
    w_busy_nxt  = r_busy;
    w_wrap      = 1'b0;
    w_frm_inc   = FRM_W'(r_frm + FRM_W'(1));

    unique case (r_state)
      ST_IDLE: begin
        w_grant_nxt = '0;
        w_disp_nxt  = '0;
        w_sel_nxt   = '0;
        w_busy_nxt  = 1'b0;
        if (w_found) begin
          w_state_nxt = ST_SHOW;
          w_owner_nxt = w_winner;
          w_ptr_nxt   = w_winner;
          w_grant_nxt = N_REQ'(1) << w_winner;
          w_disp_nxt  = w_win_data;
          w_idx_nxt   = '0;
          w_div_nxt   = '0;
          w_frm_nxt   = '0;
          w_sel_nxt   = N_DIG'(1);
          w_busy_nxt  = 1'b1;
        end
      end

      ST_SHOW: begin
        // pause freezes the scan and suspends abort checking
        if (!pause) begin
          if (r_div == DIV_LAST) begin
            w_div_nxt = '0;
            w_wrap    = (r_idx == IDX_LAST);
            w_idx_nxt = w_wrap ? '0 : IDX_W'(r_idx + IDX_W'(1));
            w_sel_nxt = N_DIG'(1) << w_idx_nxt;
            if (w_wrap) begin
              w_tick_nxt = 1'b1;
              w_frm_nxt  = w_frm_inc;
            end
            // Abort takes priority over a normal finish: no done pulse.
            if (!req[r_owner] || (w_wrap && (w_frm_inc == FRM_LAST))) begin
              w_state_nxt = ST_RELEASE;
              w_grant_nxt = '0;
              w_sel_nxt   = '0;
              w_disp_nxt  = '0;
              if (req[r_owner]) w_done_nxt = N_REQ'(1) << r_owner;
            end
          end else begin
            w_div_nxt = DIV_W'(r_div + DIV_W'(1));
          end
        end
      end

      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_sel_nxt   = '0;
        w_disp_nxt  = '0;
        w_busy_nxt  = 1'b0;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_sel_nxt   = '0;
        w_disp_nxt  = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= PTR_RST;
      r_owner <= '0;
      r_idx   <= '0;
      r_div   <= '0;
      r_frm   <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_disp  <= '0;
      r_sel   <= '0;
      r_tick  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_idx   <= w_idx_nxt;
      r_div   <= w_div_nxt;
      r_frm   <= w_frm_nxt;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_disp  <= w_disp_nxt;
      r_sel   <= w_sel_nxt;
      r_tick  <= w_tick_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign grant      = r_grant;
  assign done       = r_done;
  assign disp_data  = r_disp;
  assign digit_sel  = r_sel;
  assign frame_tick = r_tick;
  assign busy       = r_busy;

endmodule
